// File: rtl/dvp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | dvp_pkg : shared types and constants for the DVP transmitter
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package dvp_pkg;

  typedef enum logic [1:0] {
    ST_VSYNC  = 2'd0,
    ST_VBACK  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_VFRONT = 2'd3
  } dvp_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int N_BARS = 8;

  localparam rgb565_t BAR_WHITE   = 16'hFFFF;
  localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
  localparam rgb565_t BAR_CYAN    = 16'h07FF;
  localparam rgb565_t BAR_GREEN   = 16'h07E0;
  localparam rgb565_t BAR_MAGENTA = 16'hF81F;
  localparam rgb565_t BAR_RED     = 16'hF800;
  localparam rgb565_t BAR_BLUE    = 16'h001F;
  localparam rgb565_t BAR_BLACK   = 16'h0000;

  function automatic rgb565_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | dvp_tx_if : RGB565 valid/ready pixel stream feeding the DVP transmitter
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface dvp_tx_if;
  import dvp_pkg::*;

  rgb565_t pix;
  logic    pix_valid;
  logic    pix_ready;

  modport master (output pix, output pix_valid, input pix_ready);
  modport slave  (input pix, input pix_valid, output pix_ready);

endinterface
`default_nettype wire

// File: rtl/dvp_colorbar.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | dvp_colorbar : combinational pixel_x -> RGB565 eight-bar lookup
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module dvp_colorbar
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int XW       = 11
) (
  input  logic [XW-1:0] pixel_x_i,
  output rgb565_t       pixel_o
);

  localparam int BAR_W = (H_ACTIVE >= N_BARS) ? H_ACTIVE / N_BARS : 1;

  int bar_idx;

  // Blanking positions exceed the last bar; clamp instead of wrapping.
  always_comb begin
    bar_idx = int'(pixel_x_i) / BAR_W;
    if (bar_idx > N_BARS - 1) bar_idx = N_BARS - 1;
    pixel_o = bar_color(3'(bar_idx));
  end

endmodule
`default_nettype wire

// File: rtl/dvp_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | dvp_tx : byte-serial DVP sensor-side transmitter (RGB565, MSB byte first)
// | Optional colour-bar source compiled in with DVP_TX_PATTERN_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic       cmos_pclk_i,
  input  logic       rstn_i,
  dvp_tx_if.slave    pix_if,
  input  logic       pattern_sel_i,
  output logic [7:0] cmos_data_o,
  output logic       cmos_href_o,
  output logic       cmos_vsync_o,
  output logic       frame_start_o,
  output logic       underrun_o
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW          = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VW          = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);
  localparam int ACT_FIRST   = VS_LINES + V_BACK;
  localparam int ACT_END     = ACT_FIRST + V_ACTIVE;

  dvp_state_e    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    lo_q, lo_d;
  logic          href_q, href_d;
  logic          vsync_q, vsync_d;
  logic          fs_q, fs_d;
  logic          underrun_q, underrun_d;

  logic          line_end;
  logic          in_line;
  logic          slot_hi;
  logic          slot_lo;
  logic          frame_begin;
  logic          pix_ready;
  logic          pat_active;
  rgb565_t       pat_pix;
  logic [15:0]   in_pix;

  // Stage is a pure function of the line index, so zero-length stages vanish.
  function automatic dvp_state_e stage_of(input logic [VW-1:0] line);
    int li;
    li = int'(line);
    if (li < VS_LINES)       stage_of = ST_VSYNC;
    else if (li < ACT_FIRST) stage_of = ST_VBACK;
    else if (li < ACT_END)   stage_of = ST_ACTIVE;
    else                     stage_of = ST_VFRONT;
  endfunction

  always_comb begin
    line_end = (h_cnt_q == H_LAST);
    h_cnt_d  = line_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d  = v_cnt_q;
    if (line_end) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
  end

  // State register
  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_VSYNC;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (line_end) state_d = stage_of(v_cnt_d);
  end

`ifdef DVP_TX_PATTERN_EN
  logic pattern_q, pattern_d;

  always_comb pattern_d = frame_begin ? pattern_sel_i : pattern_q;

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) pattern_q <= 1'b0;
    else         pattern_q <= pattern_d;
  end

  dvp_colorbar #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (HW)
  ) u_colorbar (
    .pixel_x_i (h_cnt_q >> 1),
    .pixel_o   (pat_pix)
  );

  assign pat_active = pattern_q;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel_i;
  assign pat_active         = 1'b0;
  assign pat_pix            = '0;
`endif

  assign in_pix           = pix_if.pix;
  assign pix_if.pix_ready = pix_ready;

  // Output logic
  always_comb begin
    in_line     = (state_q == ST_ACTIVE) && (int'(h_cnt_q) < 2 * H_ACTIVE);
    slot_hi     = in_line && !h_cnt_q[0];
    slot_lo     = in_line && h_cnt_q[0];
    frame_begin = (state_q == ST_VSYNC) && (v_cnt_q == '0) && (h_cnt_q == '0);
    pix_ready   = slot_hi && !pat_active;
    href_d      = in_line;
    vsync_d     = (state_q == ST_VSYNC);
    fs_d        = frame_begin;
    data_d      = 8'h00;
    lo_d        = lo_q;
    underrun_d  = underrun_q;
    if (slot_hi) begin
      if (pat_active) begin
        data_d = pat_pix[15:8];
        lo_d   = pat_pix[7:0];
      end else if (pix_if.pix_valid) begin
        data_d = in_pix[15:8];
        lo_d   = in_pix[7:0];
      end else begin
        lo_d       = 8'h00;
        underrun_d = 1'b1;
      end
    end else if (slot_lo) begin
      data_d = lo_q;
    end
  end

  always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      data_q     <= 8'h00;
      lo_q       <= 8'h00;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      fs_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      data_q     <= data_d;
      lo_q       <= lo_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      fs_q       <= fs_d;
      underrun_q <= underrun_d;
    end
  end

  assign cmos_data_o   = data_q;
  assign cmos_href_o   = href_q;
  assign cmos_vsync_o  = vsync_q;
  assign frame_start_o = fs_q;
  assign underrun_o    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_dvp_tx : randomized self-checking bench with a frame-arithmetic model
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_dvp_tx;

  localparam int HA = 4, HB = 4, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int L     = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * L;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pattern_sel = 1'b0;
  logic [7:0] data;
  logic       href, vsync, fs, und;

  dvp_tx_if sif ();

  dvp_tx #(
    .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
    .VS_LINES (VS), .V_BACK (VB), .V_FRONT (VF)
  ) dut (
    .cmos_pclk_i   (clk),
    .rstn_i        (rstn),
    .pix_if        (sif),
    .pattern_sel_i (pattern_sel),
    .cmos_data_o   (data),
    .cmos_href_o   (href),
    .cmos_vsync_o  (vsync),
    .frame_start_o (fs),
    .underrun_o    (und)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;
  int acc_frame = 0;

  logic [7:0]  cur_data, hold;
  logic        cur_href, cur_vs, cur_fs, cur_und;
  logic [15:0] src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: actual=%0h required=%0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; acc_frame = 0;
    cur_data = 8'h00; hold = 8'h00;
    cur_href = 1'b0; cur_vs = 1'b0; cur_fs = 1'b0; cur_und = 1'b0;
  endtask

  // mode 0: always valid, incrementing; 1: random valid/data; 2: valid except 2nd slot of first active line
  task automatic run(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      int p, line, h;
      logic v, inl, slot;
      chk("vsync", vsync, cur_vs);
      chk("href", href, cur_href);
      chk("frame_start", fs, cur_fs);
      chk("data", data, cur_data);
      chk("underrun", und, cur_und);
      if (mode == 0) begin
        if (n == 1)  chk("lit_vsync_rise", vsync, 1'b1);
        if (n == 12) chk("lit_vsync_last", vsync, 1'b1);
        if (n == 13) chk("lit_vsync_fall", vsync, 1'b0);
        if (n == 24) chk("lit_href_pre", href, 1'b0);
        if (n == 25) chk("lit_byte0", {href, data}, {1'b1, 8'h12});
        if (n == 26) chk("lit_byte1", data, 8'h34);
        if (n == 28) chk("lit_byte3", data, 8'h35);
        if (n == 32) chk("lit_byte7", data, 8'h37);
        if (n == 33) chk("lit_href_post", href, 1'b0);
      end
      if (mode == 2) begin
        if (n == 206) chk("lit_und_before", und, 1'b0);
        if (n == 207) chk("lit_under_hi", {und, data}, {1'b1, 8'h00});
        if (n == 208) chk("lit_under_lo", data, 8'h00);
        if (n == 209) chk("lit_next_hi", data, 8'h12);
        if (n == 210) chk("lit_next_lo", data, 8'h4D);
      end
      p = n % FRAME; line = p / L; h = p % L;
      inl  = (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
      slot = inl && (h % 2 == 0);
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = !((line == VS + VB) && (h == 2));
      endcase
      sif.pix = src;
      sif.pix_valid = v;
      #1;
      chk("pix_ready", sif.pix_ready, slot);
      if (sif.pix_valid && sif.pix_ready) acc_frame++;
      if (p == FRAME - 1) begin
        if (mode == 0) chk("acc_per_frame", acc_frame, 8);
        acc_frame = 0;
      end
      cur_vs   = (line < VS);
      cur_href = inl;
      cur_fs   = (p == 0);
      if (slot) begin
        if (v) begin
          cur_data = src[15:8];
          hold     = src[7:0];
          src      = (mode == 1) ? 16'($urandom) : src + 16'd1;
        end else begin
          cur_data = 8'h00;
          hold     = 8'h00;
          cur_und  = 1'b1;
        end
      end else if (inl) begin
        cur_data = hold;
      end else begin
        cur_data = 8'h00;
      end
      n++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

`ifdef DVP_TX_PATTERN_EN
  localparam int HA2 = 16;
  localparam int L2 = 2 * HA2 + HB;
  localparam int FRAME2 = (VS + VB + VA + VF) * L2;
  logic       rstn2 = 1'b0;
  logic [7:0] d2_data;
  logic       d2_href, d2_vs, d2_fs, d2_und;
  logic [15:0] bars [8];
  dvp_tx_if sif2 ();

  dvp_tx #(
    .H_ACTIVE (HA2), .H_BLANK (HB), .V_ACTIVE (VA),
    .VS_LINES (VS), .V_BACK (VB), .V_FRONT (VF)
  ) dut2 (
    .cmos_pclk_i   (clk),
    .rstn_i        (rstn2),
    .pix_if        (sif2),
    .pattern_sel_i (1'b1),
    .cmos_data_o   (d2_data),
    .cmos_href_o   (d2_href),
    .cmos_vsync_o  (d2_vs),
    .frame_start_o (d2_fs),
    .underrun_o    (d2_und)
  );

  task automatic run_pattern();
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    sif2.pix = 16'h5A5A;
    sif2.pix_valid = 1'b0;
    @(negedge clk);
    rstn2 = 1'b1;
    for (int k = 0; k < FRAME2; k++) begin
      int s, h;
      logic [15:0] col;
      logic [7:0] eb;
      s = k - 1;
      h = s - (VS + VB) * L2;
      eb = 8'h00;
      if (h >= 0 && h < 2 * HA2) begin
        col = bars[(h / 2) / (HA2 / 8)];
        eb  = (h % 2 == 0) ? col[15:8] : col[7:0];
      end
      chk("pat_href", d2_href, (h >= 0 && h < 2 * HA2));
      chk("pat_data", d2_data, eb);
      chk("pat_ready", sif2.pix_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("pat_no_underrun", d2_und, 1'b0);
  endtask
`endif

  initial begin
    sif.pix = 16'h0000;
    sif.pix_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {data, href, vsync, fs, und}, 12'h000);
    rstn = 1'b1;
    src = 16'h1234;
    run(3 * FRAME, 0);
    run(FRAME, 2);
    run(2 * FRAME, 1);
    run(26, 1);
    chk("href_before_reset", href, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_outputs", {data, href, vsync, fs, und}, 12'h000);
    chk("async_reset_ready", sif.pix_ready, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    src = 16'($urandom);
    run(2 * FRAME, 1);
`ifdef DVP_TX_PATTERN_EN
    run_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
